// File: rtl/alu_mem_shifter.sv
// Memory-side serial port for the bit-serial ALU: loads 1-2 bytes, streams them LSB-first
// NSHIFT bits per ALU step while collecting the ALU result in place, then writes the bytes back.
`timescale 1ns/1ps
module alu_mem_shifter #(
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                pair,
    input  logic                load_en,
    input  logic                store_en,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic [REG_BITS-1:0] rx_data,
    output logic                shift_ready,
    input  logic                alu_active,
    output logic [NSHIFT-1:0]   to_alu,
    input  logic [NSHIFT-1:0]   from_alu,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [REG_BITS-1:0] tx_data,
    output logic                busy,
    output logic                done
);
    localparam int STEPS  = REG_BITS / NSHIFT;
    localparam int SCNT_W = $clog2(2 * STEPS);
    localparam int SR_W   = 2 * REG_BITS;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

    state_t              state, state_next;
    logic [SR_W-1:0]     sr, sr_next;
    logic                bcnt, bcnt_next;
    logic [SCNT_W-1:0]   scnt, scnt_next;
    logic                pair_q, pair_next;
    logic                store_q, store_next;
    logic                done_q;
    logic                last_byte;
    logic                last_step;

    // bcnt only ever reaches 1, so the final byte index equals the latched pair flag
    assign last_byte = (bcnt == pair_q);
    assign last_step = (scnt == (pair_q ? SCNT_W'(2 * STEPS - 1) : SCNT_W'(STEPS - 1)));

    always_comb begin
        state_next  = state;
        sr_next     = sr;
        bcnt_next   = bcnt;
        scnt_next   = scnt;
        pair_next   = pair_q;
        store_next  = store_q;
        rx_ready    = 1'b0;
        shift_ready = 1'b0;
        to_alu      = '0;
        tx_valid    = 1'b0;
        tx_data     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    pair_next  = pair;
                    store_next = store_en;
                    bcnt_next  = 1'b0;
                    scnt_next  = '0;
                    sr_next    = '0;
                    state_next = load_en ? LOAD : SHIFT;
                end
            end
            LOAD: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    sr_next[REG_BITS*bcnt +: REG_BITS] = rx_data;
                    if (last_byte) begin
                        bcnt_next  = 1'b0;
                        state_next = SHIFT;
                    end else begin
                        bcnt_next = bcnt + 1'b1;
                    end
                end
            end
            SHIFT: begin
                shift_ready = 1'b1;
                to_alu      = sr[NSHIFT-1:0];
                if (alu_active) begin
                    // Result bits enter at the top so the buffer ends up in original byte order
                    if (pair_q)
                        sr_next = {from_alu, sr[SR_W-1:NSHIFT]};
                    else
                        sr_next[REG_BITS-1:0] = {from_alu, sr[REG_BITS-1:NSHIFT]};
                    if (last_step) begin
                        scnt_next  = '0;
                        state_next = store_q ? STORE : IDLE;
                    end else begin
                        scnt_next = scnt + 1'b1;
                    end
                end
            end
            STORE: begin
                tx_valid = 1'b1;
                tx_data  = sr[REG_BITS*bcnt +: REG_BITS];
                if (tx_ready) begin
                    if (last_byte) begin
                        bcnt_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        bcnt_next = bcnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sr      <= '0;
            bcnt    <= 1'b0;
            scnt    <= '0;
            pair_q  <= 1'b0;
            store_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            sr      <= sr_next;
            bcnt    <= bcnt_next;
            scnt    <= scnt_next;
            pair_q  <= pair_next;
            store_q <= store_next;
            done_q  <= (state != IDLE) && (state_next == IDLE);
        end
    end

    assign busy = (state != IDLE);
    assign done = done_q;

endmodule
